// File: rtl/fetch_unit_pkg.sv
// Shared core package for the fetch unit: FSM state encoding, reset vector
// default, NOP encoding and datapath width.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ISSUE = 2'd2,
    S_TRAP  = 2'd3
  } fetch_state_e;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR            = 32'h0000_0013;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_next_pc_sel.sv
// next_pc_sel: purely combinational next-PC priority mux plus alignment check.
// Ports:
//   pc_plus4_i      sequential fall-through address
//   branch_taken_i  conditional branch taken, target sb_target_i
//   jal_i           unconditional jump, target uj_target_i
//   jalr_i          register jump, target jalr_target_i with bit 0 cleared
//   next_pc_o       selected next PC (jalr > jal > branch > pc+4)
//   misaligned_o    next_pc_o is not 4-byte aligned
module next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic            branch_taken_i,
  input  logic            jal_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] sb_target_i,
  input  logic [XLEN-1:0] uj_target_i,
  input  logic [XLEN-1:0] jalr_target_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misaligned_o
);

  // Priority select; jalr target has its LSB forced to zero.
  always_comb begin
    next_pc_o = pc_plus4_i;
    if (jalr_i) begin
      next_pc_o = jalr_target_i & ~XLEN'(1);
    end else if (jal_i) begin
      next_pc_o = uj_target_i;
    end else if (branch_taken_i) begin
      next_pc_o = sb_target_i;
    end
  end

  assign misaligned_o = (next_pc_o[1:0] != 2'b00);

endmodule : next_pc_sel

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM (IDLE -> REQ -> ISSUE -> REQ ..., TRAP on
// misaligned next PC). Owns PC, instruction register, exception flag and the
// issue counter.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stall                 downstream hold while in ISSUE
//   imem_req/imem_addr    instruction memory request and word address (= pc)
//   imem_rdata/imem_valid memory response
//   branch_taken/jal/jalr control-flow redirects with their targets
//   pc, pc_plus4          current instruction address and fall-through
//   instruction           registered instruction word
//   instr_valid           instruction/pc valid for decode
//   misaligned_exc        sticky misaligned-target flag
//   issue_count           instructions issued and advanced
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_valid,
  input  logic            branch_taken,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] sb_target,
  input  logic [XLEN-1:0] uj_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] instruction,
  output logic            instr_valid,
  output logic            misaligned_exc,
  output logic [XLEN-1:0] issue_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic            exc_q, exc_d;

  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] next_pc_c;
  logic            misaligned_c;

  assign pc_plus4_c = pc_q + XLEN'(4);

  next_pc_sel u_next_pc_sel (
    .pc_plus4_i     (pc_plus4_c),
    .branch_taken_i (branch_taken),
    .jal_i          (jal),
    .jalr_i         (jalr),
    .sb_target_i    (sb_target),
    .uj_target_i    (uj_target),
    .jalr_target_i  (jalr_target),
    .next_pc_o      (next_pc_c),
    .misaligned_o   (misaligned_c)
  );

  // Next-state and datapath updates; control inputs only matter in ISSUE.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    exc_d   = exc_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          if (misaligned_c) begin
            exc_d   = 1'b1;
            state_d = S_TRAP;
          end else begin
            pc_d    = next_pc_c;
            count_d = count_q + XLEN'(1);
            state_d = S_REQ;
          end
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    // Handshake outputs are registered copies of the upcoming state.
    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_ISSUE);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP_INSTR;
      count_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      exc_q   <= exc_d;
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_plus4_c;
  assign instruction    = instr_q;
  assign instr_valid    = valid_q;
  assign misaligned_exc = exc_q;
  assign issue_count    = count_q;

endmodule : fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  sole clock; every register updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  downstream hold; while high, the issued instruction and PC are frozen.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word address of the request, equal to pc.
REQ-007 imem_rdata  input  32  instruction word returned by memory.
REQ-008 imem_valid  input  1  imem_rdata is valid this cycle.
REQ-009 branch_taken  input  1  conditional branch resolved taken; target is sb_target.
REQ-010 jal  input  1  unconditional jump; target is uj_target.
REQ-011 jalr  input  1  register jump; target is jalr_target with bit 0 cleared.
REQ-012 sb_target, uj_target, jalr_target  input  32 each  precomputed targets from the immediate/ALU stage.
REQ-013 pc  output  32  address of the current instruction.
REQ-014 pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-015 instruction  output  32  registered instruction word.
REQ-016 instr_valid  output  1  instruction and pc are valid for the decode/immediate stage.
REQ-017 misaligned_exc  output  1  sticky instruction-address-misaligned flag.
REQ-018 issue_count  output  32  count of instructions issued and advanced.

Function
REQ-019 The FSM SHALL have four states: IDLE, REQ, ISSUE and TRAP.
REQ-020 IDLE SHALL hold imem_req=0, ignore imem_valid, and move to REQ on the next cycle.
REQ-021 REQ SHALL hold imem_req=1 with imem_addr=pc until imem_valid=1.
REQ-022 On that edge, REQ SHALL capture imem_rdata into instruction and move to ISSUE; response latency is unbounded.
REQ-023 In ISSUE, instr_valid SHALL be 1 and imem_req SHALL be 0.
REQ-024 With stall=1 in ISSUE, the FSM SHALL stay in ISSUE and pc, instruction and issue_count SHALL be unchanged.
REQ-025 With stall=0 in ISSUE, next_pc SHALL be selected by priority: jalr > jal > branch_taken > pc_plus4.
REQ-026 The jalr target SHALL be {jalr_target[31:1],1'b0}.
REQ-027 If next_pc[1:0]!=0, the FSM SHALL enter TRAP, leave pc unchanged and set misaligned_exc=1.
REQ-028 Otherwise, pc SHALL load next_pc, issue_count SHALL increment (wrapping at 2^32) and the FSM SHALL return to REQ.
REQ-029 Control inputs SHALL be sampled only in ISSUE with stall=0 and ignored in all other states.
REQ-030 TRAP SHALL hold imem_req=0 and instr_valid=0, and SHALL be left only by reset.
REQ-031 Arithmetic SHALL be unsigned 32-bit; pc 32'hFFFF_FFFC advances to 32'h0000_0000 without an exception.
REQ-032 Outputs SHALL be register-driven, except imem_addr (=pc) and pc_plus4, which are combinational from pc.

Reset
REQ-033 reset SHALL set state=IDLE, pc=RESET_VECTOR, instruction=32'h0000_0013 (NOP), instr_valid=0, misaligned_exc=0 and issue_count=0.
REQ-034 reset SHALL take priority over every other input, in any state, including mid-REQ.
REQ-035 A late imem_valid arriving in the IDLE cycle after reset SHALL be discarded.

Structure
REQ-036 FSM state encodings, RESET_VECTOR default and the NOP constant SHALL live in the shared core package.
REQ-037 The next-PC priority mux and alignment check SHALL be one sub-module, next_pc_sel, which is purely combinational.
REQ-038 fetch_unit SHALL own all state; the expected size is 150-250 lines.

Verification
REQ-039 Reset, then imem_valid 2 cycles after imem_req with rdata 32'h0050_0093 -> imem_addr=0, then instruction=32'h0050_0093, instr_valid=1, pc=0, pc_plus4=4.
REQ-040 ISSUE at pc=0 with branch_taken=1, sb_target=32'h10 -> next imem_addr=32'h10 and issue_count=1.
REQ-041 jal=1, uj_target=32'h40 together with branch_taken=1, sb_target=32'h10 -> pc=32'h40.
REQ-042 jalr=1, jalr_target=32'h23 -> target 32'h22, TRAP entered, misaligned_exc=1, imem_req=0 held for 10 cycles, pc unchanged.
REQ-043 stall=1 for 3 cycles in ISSUE -> instr_valid=1 and pc, instruction and issue_count constant; advances on the first cycle with stall=0.
REQ-044 reset asserted in REQ with imem_valid=1 in the following cycle -> IDLE, pc=RESET_VECTOR, no capture, instr_valid=0.
